// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32IM pipeline control slice: run-state encoding,
// register index width and the MUL/DIV latency selector.
package riscv_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  function automatic int md_latency(input logic is_div, input int mul_lat, input int div_lat);
    return is_div ? div_lat : mul_lat;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side status inputs and control outputs of the hazard controller.
// Optional perf counter signals appear when PIPE_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;
  import riscv_pkg::*;

  logic                 riscv_start;
  logic                 icache_stall;
  logic                 dcache_stall;
  logic [REG_IDX_W-1:0] if_id_rs1;
  logic [REG_IDX_W-1:0] if_id_rs2;
  logic                 if_id_use_rs1;
  logic                 if_id_use_rs2;
  logic                 id_ex_mem_read;
  logic [REG_IDX_W-1:0] id_ex_rd;
  logic                 ex_md_valid;
  logic                 ex_md_is_div;
  logic                 ex_mispredict;
  logic                 ex_halt;

  logic                 pc_en;
  logic                 load_use_stall;
  logic                 md_alu_stall;
  logic                 flush;
  logic                 id_ex_bubble;
  logic                 riscv_done;
  logic [1:0]           run_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]          perf_cycles;
  logic [31:0]          perf_stalls;
  logic [31:0]          perf_flushes;
`endif

  modport master (
    output riscv_start, icache_stall, dcache_stall, if_id_rs1, if_id_rs2,
           if_id_use_rs1, if_id_use_rs2, id_ex_mem_read, id_ex_rd,
           ex_md_valid, ex_md_is_div, ex_mispredict, ex_halt,
    input  pc_en, load_use_stall, md_alu_stall, flush, id_ex_bubble,
           riscv_done, run_state
`ifdef PIPE_PERF_CNT_EN
    , input perf_cycles, perf_stalls, perf_flushes
`endif
  );

  modport slave (
    input  riscv_start, icache_stall, dcache_stall, if_id_rs1, if_id_rs2,
           if_id_use_rs1, if_id_use_rs2, id_ex_mem_read, id_ex_rd,
           ex_md_valid, ex_md_is_div, ex_mispredict, ex_halt,
    output pc_en, load_use_stall, md_alu_stall, flush, id_ex_bubble,
           riscv_done, run_state
`ifdef PIPE_PERF_CNT_EN
    , output perf_cycles, perf_stalls, perf_flushes
`endif
  );

endinterface

// File: rtl/md_latency_counter.sv
// Times a multi-cycle MUL/DIV op in EX: stalls for LAT-1 cycles from the first
// cycle the op is seen, holds while the D$ stalls, and re-arms once the op leaves EX.
module md_latency_counter
  import riscv_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 33
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic md_valid_i,
  input  logic md_is_div_i,
  input  logic hold_i,
  input  logic freeze_i,
  output logic stall_o
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_eff;
  logic [CNT_W-1:0] load_val;
  logic             busy_q, busy_d;
  logic             first;
  logic             active;

  assign load_val = CNT_W'(md_latency(md_is_div_i, MUL_LATENCY, DIV_LATENCY) - 1);
  assign first    = en_i && md_valid_i && !busy_q;
  assign active   = first || busy_q;
  assign cnt_eff  = first ? load_val : cnt_q;
  assign stall_o  = en_i && active && (cnt_eff != '0);

  // The op stays in EX while it stalls itself or the whole pipe is frozen;
  // busy drops on the cycle it finally advances so a follow-on op reloads.
  always_comb begin
    cnt_d  = '0;
    busy_d = 1'b0;
    if (en_i && active) begin
      busy_d = stall_o || freeze_i;
      cnt_d  = (stall_o && !hold_i) ? cnt_eff - CNT_W'(1) : cnt_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Run FSM plus stall/flush/bubble arbitration for the 5-stage RV32IM pipeline.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MUL_LATENCY  = 2,
  parameter int DIV_LATENCY  = 33,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave ctrl_if
);

  localparam int                DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  run_state_e           state_q, state_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;

  logic                 md_en;
  logic                 md_stall;
  logic                 freeze;
  logic                 hz;
  logic                 pc_en;
  logic                 load_use_stall;
  logic                 flush;
  logic                 id_ex_bubble;
  logic                 riscv_done;

  logic [REG_IDX_W-1:0] src_rs [2];
  logic [1:0]           src_use;
  logic [1:0]           src_hit;

  assign src_rs[0]  = ctrl_if.if_id_rs1;
  assign src_rs[1]  = ctrl_if.if_id_rs2;
  assign src_use[0] = ctrl_if.if_id_use_rs1;
  assign src_use[1] = ctrl_if.if_id_use_rs2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_use[gi] && (src_rs[gi] == ctrl_if.id_ex_rd);
  end

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign hz = ctrl_if.id_ex_mem_read && (ctrl_if.id_ex_rd != '0) && (|src_hit);

  assign md_en = (state_q == RUN) || (state_q == DRAIN);

  md_latency_counter #(
    .MUL_LATENCY(MUL_LATENCY),
    .DIV_LATENCY(DIV_LATENCY)
  ) u_md_cnt (
    .clk        (clk),
    .reset      (reset),
    .en_i       (md_en),
    .md_valid_i (ctrl_if.ex_md_valid),
    .md_is_div_i(ctrl_if.ex_md_is_div),
    .hold_i     (ctrl_if.dcache_stall),
    .freeze_i   (ctrl_if.icache_stall || ctrl_if.dcache_stall),
    .stall_o    (md_stall)
  );

  assign freeze = ctrl_if.icache_stall || ctrl_if.dcache_stall || md_stall;

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    pc_en          = 1'b0;
    load_use_stall = 1'b0;
    flush          = 1'b0;
    id_ex_bubble   = 1'b0;
    riscv_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_if.riscv_start) state_d = RUN;
      end
      RUN: begin
        // A frozen pipe keeps the mispredicting branch in EX; it is acted on once unfrozen.
        if (freeze) begin
          pc_en = 1'b0;
        end else if (ctrl_if.ex_mispredict) begin
          flush = 1'b1;
          pc_en = 1'b1;
        end else begin
          if (hz) begin
            load_use_stall = 1'b1;
            id_ex_bubble   = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
          if (ctrl_if.ex_halt) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        flush = 1'b1;
        if (!ctrl_if.dcache_stall) begin
          if (drain_cnt_q == '0) state_d = DONE;
          else                   drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      DONE: begin
        riscv_done = 1'b1;
        if (!ctrl_if.riscv_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign ctrl_if.pc_en          = pc_en;
  assign ctrl_if.load_use_stall = load_use_stall;
  assign ctrl_if.md_alu_stall   = md_stall;
  assign ctrl_if.flush          = flush;
  assign ctrl_if.id_ex_bubble   = id_ex_bubble;
  assign ctrl_if.riscv_done     = riscv_done;
  assign ctrl_if.run_state      = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cycles_q,  perf_cycles_d;
  logic [31:0] perf_stalls_q,  perf_stalls_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic        perf_clear;
  logic        mp_flush;

  assign perf_clear = (state_q == IDLE) && (state_d == RUN);
  assign mp_flush   = (state_q == RUN) && !freeze && ctrl_if.ex_mispredict;

  // Saturating counters: hold at all-ones rather than wrap.
  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_stalls_d  = perf_stalls_q;
    perf_flushes_d = perf_flushes_q;
    if (perf_clear) begin
      perf_cycles_d  = '0;
      perf_stalls_d  = '0;
      perf_flushes_d = '0;
    end else if (state_q == RUN) begin
      if (perf_cycles_q != '1)              perf_cycles_d  = perf_cycles_q + 32'd1;
      if (!pc_en && perf_stalls_q != '1)    perf_stalls_d  = perf_stalls_q + 32'd1;
      if (mp_flush && perf_flushes_q != '1) perf_flushes_d = perf_flushes_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q  <= '0;
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_stalls_q  <= perf_stalls_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign ctrl_if.perf_cycles  = perf_cycles_q;
  assign ctrl_if.perf_stalls  = perf_stalls_q;
  assign ctrl_if.perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a priority vector table in RUN plus
// hand-written sequences for MUL/DIV timing, frozen mispredicts, drain and reset.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .MUL_LATENCY (2),
    .DIV_LATENCY (33),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ctrl_if(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       ic, dc, mr, u1, u2, mp;
    logic [4:0] rd, rs1, rs2;
    logic [4:0] exp;  // {pc_en, load_use_stall, flush, id_ex_bubble, md_alu_stall}
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input string name, input logic ic, input logic dc,
                              input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2, input logic u2,
                              input logic mp, input logic [4:0] exp);
    vec_t v;
    v.name = name; v.ic = ic; v.dc = dc; v.mr = mr; v.rd = rd;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.mp = mp; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.icache_stall   = 1'b0;
    bus.dcache_stall   = 1'b0;
    bus.if_id_rs1      = '0;
    bus.if_id_rs2      = '0;
    bus.if_id_use_rs1  = 1'b0;
    bus.if_id_use_rs2  = 1'b0;
    bus.id_ex_mem_read = 1'b0;
    bus.id_ex_rd       = '0;
    bus.ex_md_valid    = 1'b0;
    bus.ex_md_is_div   = 1'b0;
    bus.ex_mispredict  = 1'b0;
    bus.ex_halt        = 1'b0;
  endtask

  function automatic logic [4:0] outs();
    return {bus.pc_en, bus.load_use_stall, bus.flush, bus.id_ex_bubble, bus.md_alu_stall};
  endfunction

  initial begin
    int         cnt;
    logic [7:0] md_valid_seq;
    logic [7:0] md_got;

    vecs[0]  = mk("vec_idle_run",      0,0, 0,5'd0, 5'd0,0, 5'd0,0, 0, 5'b10000);
    vecs[1]  = mk("vec_lu_rs1",        0,0, 1,5'd5, 5'd5,1, 5'd0,0, 0, 5'b01010);
    vecs[2]  = mk("vec_lu_rd0",        0,0, 1,5'd0, 5'd0,1, 5'd0,1, 0, 5'b10000);
    vecs[3]  = mk("vec_lu_rs2",        0,0, 1,5'd5, 5'd1,1, 5'd5,1, 0, 5'b01010);
    vecs[4]  = mk("vec_rs2_unused",    0,0, 1,5'd5, 5'd1,1, 5'd5,0, 0, 5'b10000);
    vecs[5]  = mk("vec_not_load",      0,0, 0,5'd5, 5'd5,1, 5'd5,1, 0, 5'b10000);
    vecs[6]  = mk("vec_mispredict",    0,0, 0,5'd0, 5'd0,0, 5'd0,0, 1, 5'b10100);
    vecs[7]  = mk("vec_mp_over_lu",    0,0, 1,5'd7, 5'd7,1, 5'd0,0, 1, 5'b10100);
    vecs[8]  = mk("vec_icache_over_lu",1,0, 1,5'd7, 5'd7,1, 5'd0,0, 0, 5'b00000);
    vecs[9]  = mk("vec_dcache_over_mp",0,1, 0,5'd0, 5'd0,0, 5'd0,0, 1, 5'b00000);
    vecs[10] = mk("vec_lu_rd31",       0,0, 1,5'd31,5'd30,1,5'd31,1, 0, 5'b01010);
    vecs[11] = mk("vec_rs_mismatch",   0,0, 1,5'd9, 5'd8,1, 5'd10,1, 0, 5'b10000);

    // Reset state
    reset = 1'b1;
    bus.riscv_start = 1'b0;
    clear_inputs();
    step();
    step();
    chk("reset_outs", {27'd0, outs()}, 32'd0);
    chk("reset_state", {30'd0, bus.run_state}, 32'd0);
    chk("reset_done", {31'd0, bus.riscv_done}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("reset_perf_cycles", bus.perf_cycles, 32'd0);
`endif
    reset = 1'b0;
    step();
    chk("idle_without_start", {30'd0, bus.run_state}, 32'd0);

    // IDLE -> RUN
    bus.riscv_start = 1'b1;
    step();
    chk("start_to_run", {30'd0, bus.run_state}, 32'd1);
    chk("run_pc_en", {31'd0, bus.pc_en}, 32'd1);

    // Priority table in RUN
    for (int i = 0; i < 12; i++) begin
      bus.icache_stall   = vecs[i].ic;
      bus.dcache_stall   = vecs[i].dc;
      bus.id_ex_mem_read = vecs[i].mr;
      bus.id_ex_rd       = vecs[i].rd;
      bus.if_id_rs1      = vecs[i].rs1;
      bus.if_id_use_rs1  = vecs[i].u1;
      bus.if_id_rs2      = vecs[i].rs2;
      bus.if_id_use_rs2  = vecs[i].u2;
      bus.ex_mispredict  = vecs[i].mp;
      #1;
      chk(vecs[i].name, {27'd0, outs()}, {27'd0, vecs[i].exp});
      step();
    end
    clear_inputs();
    step();
    chk("run_after_table", {30'd0, bus.run_state}, 32'd1);

    // DIV: stall for DIV_LATENCY-1 cycles
    bus.ex_md_valid  = 1'b1;
    bus.ex_md_is_div = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (i == 0) chk("div_pc_en_low", {31'd0, bus.pc_en}, 32'd0);
      if (!bus.md_alu_stall) break;
      cnt++;
      step();
    end
    chk("div_stall_cycles", cnt, 32'd32);
    step();
    clear_inputs();

    // MUL single then back-to-back MUL,MUL
    md_valid_seq = 8'b1101_1110;
    md_got       = '0;
    for (int k = 0; k < 8; k++) begin
      bus.ex_md_valid  = md_valid_seq[7-k];
      bus.ex_md_is_div = 1'b0;
      #1;
      md_got[7-k] = bus.md_alu_stall;
      step();
    end
    chk("mul_stall_pattern", {24'd0, md_got}, {24'd0, 8'b1001_0100});
    clear_inputs();
    step();

    // Mispredict held by a 3-cycle D$ stall; load-use in the same cycle suppressed
    bus.ex_mispredict  = 1'b1;
    bus.dcache_stall   = 1'b1;
    bus.id_ex_mem_read = 1'b1;
    bus.id_ex_rd       = 5'd5;
    bus.if_id_rs1      = 5'd5;
    bus.if_id_use_rs1  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mp_frozen_c%0d", k), {27'd0, outs()}, 32'd0);
      step();
    end
    bus.dcache_stall = 1'b0;
    #1;
    chk("mp_applied", {27'd0, outs()}, {27'd0, 5'b10100});
    step();
    clear_inputs();
    step();

    // Halt -> DRAIN (one D$ stall cycle inside) -> DONE -> IDLE
    bus.ex_halt = 1'b1;
    #1;
    chk("halt_cycle_pc_en", {31'd0, bus.pc_en}, 32'd1);
    step();
    bus.ex_halt = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.run_state != 2'd2) break;
      if (cnt == 0) begin
        #1;
        chk("drain_outs", {27'd0, outs()}, {27'd0, 5'b00100});
      end
      bus.dcache_stall = (cnt == 1);
      cnt++;
      step();
    end
    bus.dcache_stall = 1'b0;
    chk("drain_cycles", cnt, 32'd5);
    chk("done_state", {30'd0, bus.run_state}, 32'd3);
    chk("done_flag", {31'd0, bus.riscv_done}, 32'd1);
    step();
    chk("done_holds_with_start", {30'd0, bus.run_state}, 32'd3);
    bus.riscv_start = 1'b0;
    step();
    chk("done_to_idle", {30'd0, bus.run_state}, 32'd0);
    chk("idle_done_low", {31'd0, bus.riscv_done}, 32'd0);

    // Reset during DRAIN
    bus.riscv_start = 1'b1;
    step();
    bus.ex_halt = 1'b1;
    step();
    bus.ex_halt = 1'b0;
    chk("in_drain", {30'd0, bus.run_state}, 32'd2);
    reset = 1'b1;
    step();
    chk("reset_drain_state", {30'd0, bus.run_state}, 32'd0);
    chk("reset_drain_outs", {27'd0, outs()}, 32'd0);
    reset = 1'b0;
    step();

    // Reset during a DIV count
    chk("rerun_state", {30'd0, bus.run_state}, 32'd1);
    bus.ex_md_valid  = 1'b1;
    bus.ex_md_is_div = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("div_mid_stall", {31'd0, bus.md_alu_stall}, 32'd1);
    reset = 1'b1;
    step();
    chk("reset_div_state", {30'd0, bus.run_state}, 32'd0);
    chk("reset_div_md_stall", {31'd0, bus.md_alu_stall}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("reset_div_perf_stalls", bus.perf_stalls, 32'd0);
`endif
    bus.ex_md_valid = 1'b0;
    reset = 1'b0;
    step();
    #1;
    chk("post_reset_no_md_stall", {27'd0, outs()}, {27'd0, 5'b10000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
